sobel_window_filter: RTL and testbench

- Consumes the three row taps from the two-line FIFO buffer: current row, one line delayed, two lines delayed.
- Forms a sliding 3x3 pixel window from those taps.
- Computes Sobel Gx/Gy and the saturated L1 gradient magnitude.
- Emits one 8-bit magnitude and a thresholded edge bit per valid window centre.
- Sits between the line buffer and the output/VGA writer stage.

---
 rtl/sobel_window_filter.sv | 137 +++++++++++++
 tb/tb_sobel_window_filter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_filter.sv
// sobel_window_filter: 3x3 Sobel edge detector fed by the three row taps of a
// two-line buffer. Three register stages: window shift, Gx/Gy, then the
// saturated |Gx|+|Gy| magnitude with its threshold bit.
module sobel_window_filter #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int THRESHOLD  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    input  logic [7:0] data0_i,
    input  logic [7:0] data1_i,
    input  logic [7:0] data2_i,
    output logic [7:0] mag_o,
    output logic       edge_o,
    output logic       valid_o,
    output logic       frame_done_o
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 3);
    localparam logic [7:0]    THR      = 8'(THRESHOLD);

    // Zero-extend a pixel into the signed gradient width.
    function automatic logic signed [10:0] ext(input logic [7:0] p);
        return signed'({3'b000, p});
    endfunction

    // win_q[r][c]: r=0 top row (data2), r=2 bottom row (data0); c=2 newest column
    logic [2:0][2:0][7:0]  win_q, win_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic                  win_valid_q, win_valid_d;
    logic                  last_q, last_d;
    logic signed [10:0]    gx_q, gx_d, gy_q, gy_d;
    logic                  valid2_q, valid2_d;
    logic                  last2_q, last2_d;
    logic [7:0]            mag_q, mag_d;
    logic                  edge_q, edge_d;
    logic                  valid3_q, valid3_d;
    logic                  fd_q, fd_d;

    logic [10:0]           abs_gx, abs_gy;
    logic [11:0]           mag_full;
    logic [7:0]            mag_sat;

    // Stage 1: shift the window and advance the column/row position on each
    // accepted pixel; the tags say whether this pixel completes a window.
    always_comb begin
        win_d       = win_q;
        col_d       = col_q;
        row_d       = row_q;
        win_valid_d = 1'b0;
        last_d      = 1'b0;
        if (valid_i) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = data2_i;
            win_d[1][2] = data1_i;
            win_d[2][2] = data0_i;
            win_valid_d = (col_q >= CW'(2));
            last_d      = (col_q == COL_LAST) && (row_q == ROW_LAST);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Stage 2: Sobel kernels on the window; range is +/-1020 so 11 bits suffice.
    always_comb begin
        gx_d = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
             - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
        gy_d = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
             - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));
        valid2_d = win_valid_q;
        last2_d  = win_valid_q & last_q;
    end

    // Stage 3: L1 magnitude saturated to 8 bits; outputs hold between valid windows.
    always_comb begin
        abs_gx   = gx_q[10] ? unsigned'(-gx_q) : unsigned'(gx_q);
        abs_gy   = gy_q[10] ? unsigned'(-gy_q) : unsigned'(gy_q);
        mag_full = {1'b0, abs_gx} + {1'b0, abs_gy};
        mag_sat  = (|mag_full[11:8]) ? 8'hFF : mag_full[7:0];
        mag_d    = valid2_q ? mag_sat : mag_q;
        edge_d   = valid2_q ? (mag_sat > THR) : edge_q;
        valid3_d = valid2_q;
        fd_d     = valid2_q & last2_q;
    end

    // All pipeline state; reset drops any in-flight pixels and restarts at col 0, row 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            last_q      <= 1'b0;
            gx_q        <= '0;
            gy_q        <= '0;
            valid2_q    <= 1'b0;
            last2_q     <= 1'b0;
            mag_q       <= '0;
            edge_q      <= 1'b0;
            valid3_q    <= 1'b0;
            fd_q        <= 1'b0;
        end else begin
            win_q       <= win_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            last_q      <= last_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            valid2_q    <= valid2_d;
            last2_q     <= last2_d;
            mag_q       <= mag_d;
            edge_q      <= edge_d;
            valid3_q    <= valid3_d;
            fd_q        <= fd_d;
        end
    end

    assign mag_o        = mag_q;
    assign edge_o       = edge_q;
    assign valid_o      = valid3_q;
    assign frame_done_o = fd_q;

endmodule

// File: tb/tb_sobel_window_filter.sv
// Directed bench for sobel_window_filter with an 8x4 image and threshold 100.
module tb_sobel_window_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_i;
    logic [7:0] data0_i, data1_i, data2_i;
    logic [7:0] mag_o;
    logic       edge_o, valid_o, frame_done_o;

    sobel_window_filter #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .THRESHOLD(100)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i),
        .data0_i(data0_i), .data1_i(data1_i), .data2_i(data2_i),
        .mag_o(mag_o), .edge_o(edge_o), .valid_o(valid_o), .frame_done_o(frame_done_o)
    );

    always #5 clk = ~clk;

    // cycle index: value of pcnt during a cycle = number of rising edges so far
    int pcnt = 0;
    always @(posedge clk) pcnt <= pcnt + 1;

    int errs = 0;
    int nchk = 0;
    int tb_col = 0;
    int q_mag[$], q_edge[$], q_fd[$], q_cyc[$], q_in[$];

    // capture every valid output away from the active edge
    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            q_mag.push_back(int'(mag_o));
            q_edge.push_back(int'(edge_o));
            q_fd.push_back(int'(frame_done_o));
            q_cyc.push_back(pcnt);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clrq();
        q_mag.delete(); q_edge.delete(); q_fd.delete(); q_cyc.delete(); q_in.delete();
    endtask

    // one accepted pixel column; remembers the input cycle of window-completing pixels
    task automatic send(input logic [7:0] a2, input logic [7:0] a1, input logic [7:0] a0);
        if (tb_col >= 2) q_in.push_back(pcnt);
        tb_col = (tb_col == 7) ? 0 : tb_col + 1;
        data2_i = a2; data1_i = a1; data0_i = a0;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; tb_col = 0;
        chk({tag, "_mag"},   mag_o, 0);
        chk({tag, "_edge"},  edge_o, 0);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_fd"},    frame_done_o, 0);
    endtask

    // vertical step: columns 0..3 dark, 4..7 at 100, same in all rows
    task automatic step_line(input bit gapped);
        for (int c = 0; c < 8; c++) begin
            send((c < 4) ? 8'd0 : 8'd100, (c < 4) ? 8'd0 : 8'd100, (c < 4) ? 8'd0 : 8'd100);
            if (gapped) idle(1);
        end
    endtask

    // windows ending at cols 4 and 5 straddle the step: Gx=400 -> 255
    function automatic int step_exp(input int i);
        return (i == 2 || i == 3) ? 255 : 0;
    endfunction

    task automatic check_step(input string tag, input int base, input bit fd_last);
        for (int i = 0; i < 6; i++) begin
            if (base + i < q_mag.size()) begin
                chk({tag, "_mag"},  q_mag[base+i], step_exp(i));
                chk({tag, "_edge"}, q_edge[base+i], (step_exp(i) == 255) ? 1 : 0);
                chk({tag, "_fd"},   q_fd[base+i], (fd_last && i == 5) ? 1 : 0);
            end
        end
    endtask

    initial begin
        int nfd;
        rst = 1'b1; valid_i = 1'b0;
        data0_i = '0; data1_i = '0; data2_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mag", mag_o, 0);
        chk("rst_edge", edge_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_fd", frame_done_o, 0);
        rst = 1'b0;

        // flat frame: 6 windows per line, 12 per frame, all zero, done on the last
        clrq();
        repeat (16) send(8'd50, 8'd50, 8'd50);
        idle(4);
        chk("flat_count", q_mag.size(), 12);
        for (int i = 0; i < 12 && i < q_mag.size(); i++) begin
            chk("flat_mag", q_mag[i], 0);
            chk("flat_edge", q_edge[i], 0);
            chk("flat_fd", q_fd[i], (i == 11) ? 1 : 0);
        end

        // vertical step, continuous (row 0)
        clrq();
        step_line(1'b0);
        idle(4);
        chk("vstep_count", q_mag.size(), 6);
        check_step("vstep", 0, 1'b0);

        // horizontal step: Gy = 30+60+30 = 120 (row 1, ends the frame)
        clrq();
        repeat (8) send(8'd0, 8'd0, 8'd30);
        idle(4);
        chk("hstep30_count", q_mag.size(), 6);
        for (int i = 0; i < 6 && i < q_mag.size(); i++) begin
            chk("hstep30_mag", q_mag[i], 120);
            chk("hstep30_edge", q_edge[i], 1);
            chk("hstep30_fd", q_fd[i], (i == 5) ? 1 : 0);
        end

        // 20 on the bottom row -> 80, below threshold (row 0)
        clrq();
        repeat (8) send(8'd0, 8'd0, 8'd20);
        idle(4);
        chk("hstep20_count", q_mag.size(), 6);
        for (int i = 0; i < 6 && i < q_mag.size(); i++) begin
            chk("hstep20_mag", q_mag[i], 80);
            chk("hstep20_edge", q_edge[i], 0);
            chk("hstep20_fd", q_fd[i], 0);
        end
        chk("hold_mag", mag_o, 80);
        chk("hold_valid", valid_o, 0);

        // gapped vertical step (row 1): same results, each output 3 cycles after its input
        clrq();
        step_line(1'b1);
        idle(4);
        chk("gap_count", q_mag.size(), 6);
        check_step("gap", 0, 1'b1);
        for (int i = 0; i < 6 && i < q_cyc.size() && i < q_in.size(); i++)
            chk("gap_latency", q_cyc[i] - q_in[i], 3);

        // reset mid-row: line 0, then cols 0..4 of line 1, then reset
        clrq();
        step_line(1'b0);
        repeat (5) send(8'd200, 8'd10, 8'd90);
        do_reset("mid_rst");
        clrq();
        idle(4);
        chk("mid_rst_flush", q_mag.size(), 0);
        step_line(1'b0);
        idle(4);
        chk("post_rst_count", q_mag.size(), 6);
        check_step("post_rst", 0, 1'b0);

        // two frames back to back
        do_reset("f2_rst");
        clrq();
        repeat (4) step_line(1'b0);
        idle(4);
        chk("f2_count", q_mag.size(), 24);
        check_step("f2_l0", 0, 1'b0);
        check_step("f2_l1", 6, 1'b1);
        check_step("f2_l2", 12, 1'b0);
        check_step("f2_l3", 18, 1'b1);
        nfd = 0;
        foreach (q_fd[i]) nfd += q_fd[i];
        chk("f2_fd_pulses", nfd, 2);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
